// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter sharing one variable-latency memory bus between instruction fetch and data access.
// Optional macro ARB_ROUND_ROBIN_EN: ties alternate between ports instead of fixed data-port priority.
module mem_bus_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_start,
    input  logic [31:0] instr_addr,
    output logic [31:0] instr_q,
    output logic        instr_done,
    input  logic        data_start,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_d,
    input  logic        data_we,
    output logic [31:0] data_q,
    output logic        data_done,
    output logic        bus_start,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_d,
    output logic        bus_we,
    input  logic [31:0] bus_q,
    input  logic        bus_done,
    output logic        busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_pend_i;
    logic        r_pend_d;
    logic [31:0] r_addr_i;
    logic [31:0] r_addr_d;
    logic [31:0] r_d_d;
    logic        r_we_d;
    logic        r_gnt_data;
    logic        r_bus_start;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_d;
    logic        r_bus_we;
    logic [31:0] r_instr_q;
    logic [31:0] r_data_q;
    logic        r_instr_done;
    logic        r_data_done;

    logic        w_acc_i;
    logic        w_acc_d;
    logic        w_cand_i;
    logic        w_cand_d;
    logic        w_pick_data;
    logic        w_grant;
    logic        w_finish;
    logic [31:0] w_win_addr;
    logic [31:0] w_win_d;
    logic        w_win_we;

    // A start is dropped while its port already holds a pending or in-flight request.
    assign w_acc_i  = instr_start & ~r_pend_i & ~((r_state == ST_WAIT) & ~r_gnt_data);
    assign w_acc_d  = data_start  & ~r_pend_d & ~((r_state == ST_WAIT) &  r_gnt_data);
    assign w_cand_i = r_pend_i | w_acc_i;
    assign w_cand_d = r_pend_d | w_acc_d;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_data;
    assign w_pick_data = w_cand_d & (~w_cand_i | ~r_last_data);
`else
    assign w_pick_data = w_cand_d;
`endif

    // Bypass: a port with nothing pending is served straight from its start inputs.
    assign w_win_addr = w_pick_data ? (r_pend_d ? r_addr_d : data_addr)
                                    : (r_pend_i ? r_addr_i : instr_addr);
    assign w_win_d    = w_pick_data ? (r_pend_d ? r_d_d : data_d) : 32'd0;
    assign w_win_we   = w_pick_data ? (r_pend_d ? r_we_d : data_we) : 1'b0;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and grant/finish decode; bus_done is ignored during the bus_start cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cand_i | w_cand_d) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (bus_done & ~r_bus_start) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Capture registers, bus launch registers and completion outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_i     <= 1'b0;
            r_pend_d     <= 1'b0;
            r_addr_i     <= 32'd0;
            r_addr_d     <= 32'd0;
            r_d_d        <= 32'd0;
            r_we_d       <= 1'b0;
            r_gnt_data   <= 1'b0;
            r_bus_start  <= 1'b0;
            r_bus_addr   <= 32'd0;
            r_bus_d      <= 32'd0;
            r_bus_we     <= 1'b0;
            r_instr_q    <= 32'd0;
            r_data_q     <= 32'd0;
            r_instr_done <= 1'b0;
            r_data_done  <= 1'b0;
        end else begin
            r_bus_start  <= w_grant;
            r_instr_done <= w_finish & ~r_gnt_data;
            r_data_done  <= w_finish &  r_gnt_data;

            if (w_grant & ~w_pick_data) begin
                r_pend_i <= 1'b0;
            end else if (w_acc_i) begin
                r_pend_i <= 1'b1;
                r_addr_i <= instr_addr;
            end

            if (w_grant & w_pick_data) begin
                r_pend_d <= 1'b0;
            end else if (w_acc_d) begin
                r_pend_d <= 1'b1;
                r_addr_d <= data_addr;
                r_d_d    <= data_d;
                r_we_d   <= data_we;
            end

            if (w_grant) begin
                r_bus_addr <= w_win_addr;
                r_bus_d    <= w_win_d;
                r_bus_we   <= w_win_we;
                r_gnt_data <= w_pick_data;
            end

            if (w_finish & r_gnt_data) begin
                r_data_q <= bus_q;
            end else if (w_finish) begin
                r_instr_q <= bus_q;
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Last-grant register; resets to data so the first tie goes to instr.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_data <= 1'b1;
        end else if (w_grant) begin
            r_last_data <= w_pick_data;
        end
    end
`endif

    assign instr_q    = r_instr_q;
    assign instr_done = r_instr_done;
    assign data_q     = r_data_q;
    assign data_done  = r_data_done;
    assign bus_start  = r_bus_start;
    assign bus_addr   = r_bus_addr;
    assign bus_d      = r_bus_d;
    assign bus_we     = r_bus_we;
    assign busy       = (r_state == ST_WAIT);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a queue-based request/transaction model.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_start;
    logic [31:0] instr_addr;
    logic [31:0] instr_q;
    logic        instr_done;
    logic        data_start;
    logic [31:0] data_addr;
    logic [31:0] data_d;
    logic        data_we;
    logic [31:0] data_q;
    logic        data_done;
    logic        bus_start;
    logic [31:0] bus_addr;
    logic [31:0] bus_d;
    logic        bus_we;
    logic [31:0] bus_q;
    logic        bus_done;
    logic        busy;

    mem_bus_arbiter dut (
        .clk(clk), .reset(reset),
        .instr_start(instr_start), .instr_addr(instr_addr), .instr_q(instr_q), .instr_done(instr_done),
        .data_start(data_start), .data_addr(data_addr), .data_d(data_d), .data_we(data_we),
        .data_q(data_q), .data_done(data_done),
        .bus_start(bus_start), .bus_addr(bus_addr), .bus_d(bus_d), .bus_we(bus_we),
        .bus_q(bus_q), .bus_done(bus_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- memory responder ----------------
    bit          rsp_en = 1'b1;
    bit          rsp_fixed = 1'b1;
    bit          rsp_noise = 1'b0;
    int          rsp_k = 1;
    logic [31:0] rsp_val = 32'd0;
    int          rsp_cnt = 0;

    always @(negedge clk) begin
        if (rsp_en) begin
            if (!busy) begin
                rsp_cnt  = 0;
                bus_done = 1'b0;
            end else if (bus_start) begin
                rsp_cnt  = (rsp_k == 0) ? int'($urandom_range(1, 4)) : rsp_k;
                bus_done = rsp_noise && ($urandom % 4 == 0);
                bus_q    = $urandom;
            end else if (rsp_cnt > 0) begin
                rsp_cnt--;
                bus_done = (rsp_cnt == 0);
                bus_q    = rsp_fixed ? rsp_val : $urandom;
            end else begin
                bus_done = 1'b0;
            end
        end else begin
            rsp_cnt = 0;
        end
    end

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic        we;
    } req_t;

    req_t        mq_i[$];
    req_t        mq_d[$];
    req_t        m_r;
    bit          m_valid = 1'b0;
    bit          m_busy, m_launch, m_port_d, m_last_d, m_pick_d;
    bit          e_d_known;
    logic [31:0] e_addr, e_d, e_iq, e_dq;
    logic        e_we, e_bs, e_idone, e_ddone;

    always @(posedge clk) begin
        e_bs = 1'b0; e_idone = 1'b0; e_ddone = 1'b0;
        if (reset) begin
            mq_i.delete(); mq_d.delete();
            m_busy = 1'b0; m_launch = 1'b0; m_last_d = 1'b1;
            e_addr = 32'd0; e_d = 32'd0; e_we = 1'b0; e_iq = 32'd0; e_dq = 32'd0;
            e_d_known = 1'b1; m_valid = 1'b1;
        end else if (m_valid) begin
            if (instr_start && mq_i.size() == 0 && !(m_busy && !m_port_d)) begin
                m_r.a = instr_addr; m_r.d = 32'd0; m_r.we = 1'b0;
                mq_i.push_back(m_r);
            end
            if (data_start && mq_d.size() == 0 && !(m_busy && m_port_d)) begin
                m_r.a = data_addr; m_r.d = data_d; m_r.we = data_we;
                mq_d.push_back(m_r);
            end
            if (m_busy) begin
                if (bus_done && !m_launch) begin
                    if (m_port_d) begin e_ddone = 1'b1; e_dq = bus_q; end
                    else begin e_idone = 1'b1; e_iq = bus_q; end
                    m_busy = 1'b0;
                end
                m_launch = 1'b0;
            end else if (mq_i.size() + mq_d.size() > 0) begin
`ifdef ARB_ROUND_ROBIN_EN
                if (mq_i.size() > 0 && mq_d.size() > 0) m_pick_d = !m_last_d;
`else
                if (mq_i.size() > 0 && mq_d.size() > 0) m_pick_d = 1'b1;
`endif
                else m_pick_d = (mq_d.size() > 0);
                if (m_pick_d) m_r = mq_d.pop_front();
                else m_r = mq_i.pop_front();
                e_addr = m_r.a; e_d = m_r.d; e_we = m_r.we; e_d_known = m_pick_d;
                m_port_d = m_pick_d; m_last_d = m_pick_d;
                m_busy = 1'b1; m_launch = 1'b1; e_bs = 1'b1;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            check("bus_start", 32'(bus_start), 32'(e_bs));
            check("busy", 32'(busy), 32'(m_busy));
            check("instr_done", 32'(instr_done), 32'(e_idone));
            check("data_done", 32'(data_done), 32'(e_ddone));
            check("instr_q", instr_q, e_iq);
            check("data_q", data_q, e_dq);
            check("bus_addr", bus_addr, e_addr);
            check("bus_we", 32'(bus_we), 32'(e_we));
            if (e_d_known) check("bus_d", bus_d, e_d);
        end
    end

    // ---------------- directed + random stimulus ----------------
    logic [31:0] exp_first, exp_second;
    int nbs, nid, ndone;

    initial begin
        reset = 1'b1; instr_start = 1'b0; instr_addr = 32'd0;
        data_start = 1'b0; data_addr = 32'd0; data_d = 32'd0; data_we = 1'b0;
        bus_q = 32'd0; bus_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bus_start", 32'(bus_start), 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_instr_q", instr_q, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // single fetch, k=2
        rsp_k = 2; rsp_val = 32'hDEADBEEF;
        instr_start = 1'b1; instr_addr = 32'h100;
        @(negedge clk); instr_start = 1'b0;
        check("fetch_bus_start", 32'(bus_start), 32'd1);
        check("fetch_bus_addr", bus_addr, 32'h100);
        check("fetch_bus_we", 32'(bus_we), 32'd0);
        repeat (3) @(negedge clk);
        check("fetch_done", 32'(instr_done), 32'd1);
        check("fetch_q", instr_q, 32'hDEADBEEF);

        // data write, k=3
        @(negedge clk);
        rsp_k = 3; rsp_val = 32'h0BADF00D;
        data_start = 1'b1; data_addr = 32'h2000; data_d = 32'h12345678; data_we = 1'b1;
        @(negedge clk); data_start = 1'b0; data_we = 1'b0; data_d = 32'd0;
        for (int i = 0; i < 4; i++) begin
            check("wr_bus_we", 32'(bus_we), 32'd1);
            check("wr_bus_d", bus_d, 32'h12345678);
            @(negedge clk);
        end
        ndone = 0;
        for (int i = 0; i < 4; i++) begin
            if (data_done) ndone++;
            @(negedge clk);
        end
        check("wr_done_count", 32'(ndone), 32'd1);

        // tie, then instr start in the first done cycle
`ifdef ARB_ROUND_ROBIN_EN
        exp_first = 32'h10; exp_second = 32'h20;
`else
        exp_first = 32'h20; exp_second = 32'h10;
`endif
        rsp_k = 1; rsp_val = 32'h55AA55AA;
        instr_start = 1'b1; instr_addr = 32'h10; data_start = 1'b1; data_addr = 32'h20;
        @(negedge clk); instr_start = 1'b0; data_start = 1'b0;
        check("tie_first", bus_addr, exp_first);
        repeat (2) @(negedge clk);
        instr_start = 1'b1; instr_addr = 32'h30;
        @(negedge clk); instr_start = 1'b0;
        check("tie_second_start", 32'(bus_start), 32'd1);
        check("tie_second", bus_addr, exp_second);
        repeat (8) @(negedge clk);

        // duplicate start while in flight
        rsp_k = 3; nbs = 0; nid = 0;
        instr_start = 1'b1; instr_addr = 32'h40;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            instr_start = (i == 2);
            instr_addr = 32'h44;
            if (bus_start) nbs++;
            if (instr_done) nid++;
        end
        check("dup_bus_starts", 32'(nbs), 32'd1);
        check("dup_instr_dones", 32'(nid), 32'd1);

        // reset during WAIT, stale bus_done right after
        rsp_k = 4;
        instr_start = 1'b1; instr_addr = 32'h50;
        @(negedge clk); instr_start = 1'b0;
        @(negedge clk);
        rsp_en = 1'b0; bus_done = 1'b0; reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        check("rstop_busy", 32'(busy), 32'd0);
        check("rstop_bus_addr", bus_addr, 32'd0);
        check("rstop_instr_q", instr_q, 32'd0);
        check("rstop_data_q", data_q, 32'd0);
        @(negedge clk); bus_done = 1'b1; bus_q = 32'hFFFFFFFF;
        @(negedge clk); bus_done = 1'b0;
        nbs = 0; nid = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus_start || busy) nbs++;
            if (instr_done || data_done) nid++;
            @(negedge clk);
        end
        check("rstop_no_bus", 32'(nbs), 32'd0);
        check("rstop_no_done", 32'(nid), 32'd0);
        rsp_en = 1'b1;

        // back-to-back data reads, k=1
        rsp_k = 1;
        for (int i = 0; i < 10; i++) begin
            rsp_val = 32'hA0000000 + 32'(i);
            data_start = 1'b1; data_addr = 32'(i * 4); data_we = 1'b0;
            @(negedge clk); data_start = 1'b0;
            check("b2b_bus_start", 32'(bus_start), 32'd1);
            repeat (2) @(negedge clk);
            check("b2b_done", 32'(data_done), 32'd1);
            check("b2b_q", data_q, rsp_val);
        end
        @(negedge clk);

        // randomized traffic
        rsp_fixed = 1'b0; rsp_k = 0; rsp_noise = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            instr_start = ($urandom % 4 == 0);
            instr_addr  = $urandom;
            data_start  = ($urandom % 4 == 0);
            data_addr   = $urandom;
            data_d      = $urandom;
            data_we     = $urandom % 2;
            reset       = ($urandom % 400 == 0);
        end
        @(negedge clk);
        instr_start = 1'b0; data_start = 1'b0; reset = 1'b0;
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
